// File: rtl/banco_registros_param.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | banco_registros_param: XLEN x NREGS register file with 2R/1W ports,       |
// | pending-write scoreboard and a one-register-per-cycle clear engine.       |
// | Optional macro REGFILE_BYPASS_EN enables write-through read forwarding.   |
// | Revision: 1.0                                                             |
// +--------------------------------------------------------------------------+
module banco_registros_param #(
  parameter int  XLEN  = 32,
  parameter int  NREGS = 32,
  localparam int AW    = $clog2(NREGS)
) (
  input  logic            CLK,
  input  logic            RST_n,
  input  logic            clr_req,
  output logic            ready,
  input  logic [AW-1:0]   rs1_addr,
  input  logic [AW-1:0]   rs2_addr,
  output logic [XLEN-1:0] rs1_data,
  output logic [XLEN-1:0] rs2_data,
  output logic            rs1_busy,
  output logic            rs2_busy,
  input  logic            issue_valid,
  input  logic [AW-1:0]   issue_rd,
  input  logic            we,
  input  logic [AW-1:0]   wr_addr,
  input  logic [XLEN-1:0] wr_data
);

  localparam int          NPORTS   = 2;
  localparam logic [AW-1:0] LAST_REG = AW'(NREGS - 1);

  typedef enum logic [0:0] {
    S_CLEAR = 1'b0,
    S_IDLE  = 1'b1
  } state_t;

  state_t            state;
  logic [AW-1:0]     cnt;
  logic [NREGS-1:0]  busy;
  logic [NREGS-1:0]  busy_next;
  logic [XLEN-1:0]   regs [NREGS];

  logic              wr_fire;
  logic              issue_fire;

  assign wr_fire    = (state == S_IDLE) && we && (wr_addr != '0);
  assign issue_fire = (state == S_IDLE) && issue_valid && (issue_rd != '0);

  // Set after clear so a same-cycle issue to the written register stays pending.
  always_comb begin
    busy_next = busy;
    if (wr_fire) begin
      busy_next[wr_addr] = 1'b0;
    end
    if (issue_fire) begin
      busy_next[issue_rd] = 1'b1;
    end
    busy_next[0] = 1'b0;
  end

  always_ff @(posedge CLK) begin
    if (!RST_n) begin
      state <= S_CLEAR;
      cnt   <= '0;
      busy  <= '0;
      ready <= 1'b0;
    end else begin
      case (state)
        S_CLEAR: begin
          cnt <= cnt + 1'b1;
          if (cnt == LAST_REG) begin
            state <= S_IDLE;
            ready <= 1'b1;
          end
        end
        S_IDLE: begin
          if (clr_req) begin
            state <= S_CLEAR;
            cnt   <= '0;
            busy  <= '0;
            ready <= 1'b0;
          end else begin
            busy <= busy_next;
          end
        end
        default: begin
          state <= S_CLEAR;
          cnt   <= '0;
          busy  <= '0;
          ready <= 1'b0;
        end
      endcase
    end
  end

  // Storage has no reset of its own; the clear engine zeroes it after reset.
  always_ff @(posedge CLK) begin
    if (RST_n) begin
      if (state == S_CLEAR) begin
        regs[cnt] <= '0;
      end else if (wr_fire) begin
        regs[wr_addr] <= wr_data;
      end
    end
  end

  logic [AW-1:0] rd_addr [NPORTS];
  logic [XLEN:0] rd_word [NPORTS];

  assign rd_addr[0] = rs1_addr;
  assign rd_addr[1] = rs2_addr;

  for (genvar p = 0; p < NPORTS; p++) begin : g_rdport
    logic [XLEN-1:0] data;
    logic            bsy;
    logic            hit;

`ifdef REGFILE_BYPASS_EN
    assign hit = wr_fire && (wr_addr == rd_addr[p]);
`else
    assign hit = 1'b0;
`endif

    always_comb begin
      data = '0;
      bsy  = 1'b0;
      if ((state == S_IDLE) && (rd_addr[p] != '0)) begin
        data = regs[rd_addr[p]];
        bsy  = busy[rd_addr[p]];
      end
      if (hit) begin
        data = wr_data;
        bsy  = 1'b0;
      end
    end

    assign rd_word[p] = {bsy, data};
  end

  assign rs1_data = rd_word[0][XLEN-1:0];
  assign rs1_busy = rd_word[0][XLEN];
  assign rs2_data = rd_word[1][XLEN-1:0];
  assign rs2_busy = rd_word[1][XLEN];

endmodule
`default_nettype wire

// File: tb/tb_banco_registros_param.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | tb_banco_registros_param: directed plus random stimulus against a        |
// | behavioural register-file/scoreboard model. Revision: 1.0                |
// +--------------------------------------------------------------------------+
module tb_banco_registros_param;

  localparam int XLEN  = 32;
  localparam int NREGS = 32;
  localparam int AW    = $clog2(NREGS);

  logic            CLK = 1'b0;
  logic            RST_n = 1'b0;
  logic            clr_req = 1'b0;
  logic            ready;
  logic [AW-1:0]   rs1_addr = '0;
  logic [AW-1:0]   rs2_addr = '0;
  logic [XLEN-1:0] rs1_data;
  logic [XLEN-1:0] rs2_data;
  logic            rs1_busy;
  logic            rs2_busy;
  logic            issue_valid = 1'b0;
  logic [AW-1:0]   issue_rd = '0;
  logic            we = 1'b0;
  logic [AW-1:0]   wr_addr = '0;
  logic [XLEN-1:0] wr_data = '0;

  always #5 CLK = ~CLK;

  banco_registros_param #(.XLEN(XLEN), .NREGS(NREGS)) dut (
    .CLK(CLK), .RST_n(RST_n), .clr_req(clr_req), .ready(ready),
    .rs1_addr(rs1_addr), .rs2_addr(rs2_addr),
    .rs1_data(rs1_data), .rs2_data(rs2_data),
    .rs1_busy(rs1_busy), .rs2_busy(rs2_busy),
    .issue_valid(issue_valid), .issue_rd(issue_rd),
    .we(we), .wr_addr(wr_addr), .wr_data(wr_data)
  );

  int total = 0;
  int bad   = 0;

  // Reference: architectural contents, pending bits, and cycles of clear left.
  logic [XLEN-1:0] m_regs [NREGS];
  bit              m_busy [NREGS];
  int              m_clear = 0;

  logic            seen_ready;
  logic [XLEN-1:0] seen_d1, seen_d2;
  logic            seen_b1, seen_b2;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    if (obs !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic model_read(input logic [AW-1:0] a, output logic [XLEN-1:0] d, output logic b);
    d = '0;
    b = 1'b0;
    if (m_clear == 0) begin
      if (a != '0) begin
        d = m_regs[a];
        b = m_busy[a];
      end
`ifdef REGFILE_BYPASS_EN
      if (we && (wr_addr != '0) && (wr_addr == a)) begin
        d = wr_data;
        b = 1'b0;
      end
`endif
    end
  endtask

  task automatic model_wipe();
    for (int i = 0; i < NREGS; i++) begin
      m_regs[i] = '0;
      m_busy[i] = 1'b0;
    end
    m_clear = NREGS;
  endtask

  task automatic model_edge();
    if (!RST_n) begin
      model_wipe();
    end else if (m_clear > 0) begin
      m_clear--;
    end else if (clr_req) begin
      model_wipe();
    end else begin
      if (we && (wr_addr != '0)) begin
        m_regs[wr_addr] = wr_data;
        m_busy[wr_addr] = 1'b0;
      end
      if (issue_valid && (issue_rd != '0)) begin
        m_busy[issue_rd] = 1'b1;
      end
    end
  endtask

  task automatic cycle();
    logic [XLEN-1:0] ed;
    logic            eb;
    @(negedge CLK);
    seen_ready = ready;
    seen_d1 = rs1_data;  seen_b1 = rs1_busy;
    seen_d2 = rs2_data;  seen_b2 = rs2_busy;
    check("ready", 64'(ready), 64'(m_clear == 0));
    model_read(rs1_addr, ed, eb);
    check("rs1_data", 64'(rs1_data), 64'(ed));
    check("rs1_busy", 64'(rs1_busy), 64'(eb));
    model_read(rs2_addr, ed, eb);
    check("rs2_data", 64'(rs2_data), 64'(ed));
    check("rs2_busy", 64'(rs2_busy), 64'(eb));
    @(posedge CLK);
    model_edge();
    #1;
  endtask

  task automatic wait_ready(output int n);
    n = 100;
    for (int k = 0; k < 100; k++) begin
      cycle();
      if (seen_ready) begin
        n = k;
        return;
      end
    end
  endtask

  task automatic idle_inputs();
    we = 1'b0;
    issue_valid = 1'b0;
    clr_req = 1'b0;
  endtask

  initial begin
    int n;

    RST_n = 1'b0;
    @(posedge CLK);
    model_edge();
    #1;
    RST_n = 1'b1;
    wait_ready(n);
    check("rst_len", 64'(n), 64'(NREGS));

    for (int i = 0; i < NREGS; i++) begin
      rs1_addr = AW'(i);
      rs2_addr = AW'(NREGS - 1 - i);
      cycle();
      check("rst_zero", 64'({seen_b1, seen_d1}), 64'(0));
    end

    we = 1'b1; wr_addr = 5; wr_data = 32'hDEADBEEF; rs1_addr = 0; rs2_addr = 0;
    cycle();
    we = 1'b0; rs1_addr = 5; rs2_addr = 0;
    cycle();
    check("wr5", 64'(seen_d1), 64'(32'hDEADBEEF));
    check("wr5_x0", 64'(seen_d2), 64'(0));

    we = 1'b1; wr_addr = 0; wr_data = 32'h1234;
    cycle();
    we = 1'b0; rs1_addr = 0;
    cycle();
    check("x0_write", 64'(seen_d1), 64'(0));

    issue_valid = 1'b1; issue_rd = 7;
    cycle();
    issue_valid = 1'b0; rs1_addr = 7;
    cycle();
    check("busy7_set", 64'(seen_b1), 64'(1));
    we = 1'b1; wr_addr = 7; wr_data = 32'h77; issue_valid = 1'b1; issue_rd = 7;
    cycle();
    idle_inputs();
    cycle();
    check("busy7_hold", 64'(seen_b1), 64'(1));
    we = 1'b1; wr_addr = 7;
    cycle();
    we = 1'b0;
    cycle();
    check("busy7_clr", 64'(seen_b1), 64'(0));

    we = 1'b1; wr_addr = 3; wr_data = 32'h55; rs2_addr = 3;
    cycle();
`ifdef REGFILE_BYPASS_EN
    check("byp_same", 64'({seen_b2, seen_d2}), 64'(32'h55));
`else
    check("byp_same", 64'(seen_d2), 64'(0));
`endif
    we = 1'b0;
    cycle();
    check("byp_next", 64'(seen_d2), 64'(32'h55));

    for (int i = 1; i < NREGS; i++) begin
      we = 1'b1; wr_addr = AW'(i); wr_data = XLEN'(i);
      cycle();
    end
    we = 1'b0; issue_valid = 1'b1; issue_rd = 9;
    cycle();
    issue_valid = 1'b0; clr_req = 1'b1;
    cycle();
    clr_req = 1'b0;
    for (int k = 0; k < NREGS - 1; k++) begin
      we = 1'b1; wr_addr = AW'($urandom_range(1, NREGS - 1)); wr_data = $urandom;
      issue_valid = 1'b1; issue_rd = AW'($urandom_range(1, NREGS - 1));
      clr_req = 1'($urandom_range(0, 1));
      rs1_addr = AW'($urandom_range(0, NREGS - 1)); rs2_addr = wr_addr;
      cycle();
    end
    idle_inputs();
    wait_ready(n);
    check("clr_len", 64'(n + NREGS - 1), 64'(NREGS));
    for (int i = 0; i < NREGS; i++) begin
      rs1_addr = AW'(i);
      rs2_addr = AW'(i);
      cycle();
      check("clr_zero", 64'({seen_b1, seen_d1}), 64'(0));
    end

    clr_req = 1'b1;
    cycle();
    clr_req = 1'b0;
    repeat (10) cycle();
    RST_n = 1'b0;
    cycle();
    RST_n = 1'b1;
    wait_ready(n);
    check("rst_mid_len", 64'(n), 64'(NREGS));

    repeat (3000) begin
      RST_n       = ($urandom_range(0, 299) != 0);
      clr_req     = ($urandom_range(0, 79) == 0);
      we          = 1'($urandom_range(0, 1));
      wr_addr     = AW'($urandom_range(0, NREGS - 1));
      wr_data     = $urandom;
      issue_valid = 1'($urandom_range(0, 1));
      issue_rd    = ($urandom_range(0, 3) == 0) ? wr_addr : AW'($urandom_range(0, NREGS - 1));
      rs1_addr    = ($urandom_range(0, 3) == 0) ? wr_addr : AW'($urandom_range(0, NREGS - 1));
      rs2_addr    = ($urandom_range(0, 3) == 0) ? issue_rd : AW'($urandom_range(0, NREGS - 1));
      cycle();
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire
